// File: rtl/ps2_host_fifo_if.sv
// CSR bus bundle for the PS/2 host controller.
// The bus master drives address, write strobe and write data; the controller returns registered read data.
interface ps2_host_fifo_if;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;

    modport master (output csr_a, output csr_we, output csr_di, input csr_do);
    modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/ps2_host_fifo.sv
// PS/2 host controller: filtered RX into a scancode FIFO, acknowledged TX, sticky error flags, maskable IRQ.
// Pads are open-drain: o_*_oe=1 pulls the line low, 0 releases it; i_* is the resolved line level.
//   state     | meaning
//   S_IDLE    | waiting for a start bit or a TXDATA write
//   S_RX      | shifting in a device frame
//   S_INHIBIT | host holds clock low for 100 us
//   S_REQ     | data low, clock released (request to send)
//   S_TX      | driving data bits and parity on device clock falls
//   S_STOP    | data released, sampling the device ACK
//   S_ACKW    | waiting for clock and data to return high
//   S_DONE    | flag completion
module ps2_host_fifo #(
    parameter logic [3:0]  csr_addr      = 4'h0,
    parameter int unsigned clk_freq      = 100000000,
    parameter int unsigned rx_depth_log2 = 4,
    parameter int unsigned filter_len    = 8
) (
    input  logic           i_sys_clk,
    input  logic           i_sys_rst,
    ps2_host_fifo_if.slave csr,
    input  logic           i_ps2_clk,
    input  logic           i_ps2_data,
    output logic           o_ps2_clk_oe,
    output logic           o_ps2_data_oe,
    output logic           o_irq
);

    localparam int unsigned PW    = rx_depth_log2;
    localparam int unsigned DEPTH = 1 << rx_depth_log2;
    localparam logic [31:0] T_2MS  = 32'(clk_freq / 500);
    localparam logic [31:0] T_15MS = 32'(clk_freq / 1000 * 15);
    localparam logic [31:0] T_INH  = 32'(clk_freq / 10000);
    localparam logic [7:0]  FILT_RLD = 8'(filter_len - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_INHIBIT, S_REQ, S_TX, S_STOP, S_ACKW, S_DONE
    } state_t;

    logic       r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic       r_clk_f, r_clk_fd;
    logic [7:0] r_filt;
    logic       w_fall;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_clk_f  <= 1'b1;
            r_clk_fd <= 1'b1;
            r_filt   <= FILT_RLD;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_clk_fd <= r_clk_f;
            if (r_clk_s2 == r_clk_f) begin
                r_filt <= FILT_RLD;
            end else if (r_filt == 8'd0) begin
                r_clk_f <= r_clk_s2;
                r_filt  <= FILT_RLD;
            end else begin
                r_filt <= r_filt - 8'd1;
            end
        end
    end

    assign w_fall = r_clk_fd & ~r_clk_f;

    logic       w_sel, w_rd, w_wr, w_w1c, w_tx_wr, w_pop;
    logic [1:0] w_reg;

    assign w_sel = (csr.csr_a[13:10] == csr_addr);
    assign w_rd  = w_sel & ~csr.csr_we;
    assign w_wr  = w_sel & csr.csr_we;
    assign w_reg = csr.csr_a[1:0];
    assign w_w1c = w_wr & (w_reg == 2'd2);

    state_t      r_state, w_state_n;
    logic [3:0]  r_bit, w_bit_n;
    logic [9:0]  r_sr, w_sr_n;
    logic [31:0] r_tmr, w_tmr_n;
    logic [7:0]  r_tx_byte, w_tx_byte_n;
    logic        r_clk_oe, w_clk_oe_n, r_dat_oe, w_dat_oe_n;
    logic        w_push, w_set_nack, w_set_to, w_set_done;
    logic        w_tx_busy, w_tmr_tc;
    logic [8:0]  w_tx_bits;
    logic [10:0] w_rx_word;
    logic [9:0]  w_rx_entry;
    logic [2:0]  r_ctrl;

    assign w_tx_busy  = (r_state != S_IDLE) && (r_state != S_RX);
    assign w_tx_wr    = w_wr & (w_reg == 2'd1) & ~w_tx_busy;
    assign w_tmr_tc   = (r_tmr == 32'd0);
    assign w_tx_bits  = {~^r_tx_byte, r_tx_byte};
    assign w_rx_word  = {r_dat_s2, r_sr};
    assign w_rx_entry = {~w_rx_word[10], ~^w_rx_word[9:1], w_rx_word[8:1]};

    always_comb begin
        w_state_n   = r_state;
        w_bit_n     = r_bit;
        w_sr_n      = r_sr;
        w_tx_byte_n = r_tx_byte;
        w_tmr_n     = w_tmr_tc ? 32'd0 : r_tmr - 32'd1;
        w_clk_oe_n  = 1'b0;
        w_dat_oe_n  = r_dat_oe;
        w_push      = 1'b0;
        w_set_nack  = 1'b0;
        w_set_to    = 1'b0;
        w_set_done  = 1'b0;
        case (r_state)
            S_IDLE, S_RX: begin
                w_dat_oe_n = 1'b0;
                w_clk_oe_n = (r_state == S_IDLE) & r_ctrl[2];
                if (w_tx_wr) begin
                    // a TX request abandons any partially received frame
                    w_tx_byte_n = csr.csr_di[7:0];
                    w_tmr_n     = T_INH - 32'd1;
                    w_clk_oe_n  = 1'b1;
                    w_bit_n     = 4'd0;
                    w_state_n   = S_INHIBIT;
                end else if (w_fall && !r_clk_oe) begin
                    w_sr_n  = {r_dat_s2, r_sr[9:1]};
                    w_tmr_n = T_2MS;
                    if (r_state == S_IDLE) begin
                        if (!r_dat_s2) begin
                            w_bit_n   = 4'd1;
                            w_state_n = S_RX;
                        end
                    end else if (r_bit == 4'd10) begin
                        w_push    = 1'b1;
                        w_bit_n   = 4'd0;
                        w_state_n = S_IDLE;
                    end else begin
                        w_bit_n = r_bit + 4'd1;
                    end
                end else if (r_state == S_RX && w_tmr_tc) begin
                    w_set_to  = 1'b1;
                    w_bit_n   = 4'd0;
                    w_state_n = S_IDLE;
                end
            end
            S_INHIBIT: begin
                w_clk_oe_n = 1'b1;
                if (w_tmr_tc) begin
                    w_dat_oe_n = 1'b1;
                    w_state_n  = S_REQ;
                end
            end
            S_REQ: begin
                w_dat_oe_n = 1'b1;
                w_tmr_n    = T_15MS;
                w_state_n  = S_TX;
            end
            S_TX: begin
                if (w_fall) begin
                    w_tmr_n = T_2MS;
                    if (r_bit == 4'd9) begin
                        w_dat_oe_n = 1'b0;
                        w_bit_n    = 4'd0;
                        w_state_n  = S_STOP;
                    end else begin
                        w_dat_oe_n = ~w_tx_bits[r_bit];
                        w_bit_n    = r_bit + 4'd1;
                    end
                end else if (w_tmr_tc) begin
                    w_dat_oe_n = 1'b0;
                    w_set_to   = 1'b1;
                    w_set_done = 1'b1;
                    w_bit_n    = 4'd0;
                    w_state_n  = S_IDLE;
                end
            end
            S_STOP: begin
                if (w_fall) begin
                    w_set_nack = r_dat_s2;
                    w_tmr_n    = T_2MS;
                    w_state_n  = S_ACKW;
                end else if (w_tmr_tc) begin
                    w_set_to   = 1'b1;
                    w_set_done = 1'b1;
                    w_state_n  = S_IDLE;
                end
            end
            S_ACKW: begin
                if (r_clk_f && r_dat_s2) begin
                    w_state_n = S_DONE;
                end else if (w_tmr_tc) begin
                    w_set_to   = 1'b1;
                    w_set_done = 1'b1;
                    w_state_n  = S_IDLE;
                end
            end
            S_DONE: begin
                w_set_done = 1'b1;
                w_state_n  = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state   <= S_IDLE;
            r_bit     <= 4'd0;
            r_sr      <= 10'd0;
            r_tmr     <= 32'd0;
            r_tx_byte <= 8'd0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_bit     <= w_bit_n;
            r_sr      <= w_sr_n;
            r_tmr     <= w_tmr_n;
            r_tx_byte <= w_tx_byte_n;
            r_clk_oe  <= w_clk_oe_n;
            r_dat_oe  <= w_dat_oe_n;
        end
    end

    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_dat_oe;

    logic [9:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0]   r_cnt;
    logic          w_empty, w_full, w_push_ok, w_set_ovf;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == (PW+1)'(DEPTH));
    assign w_pop     = w_rd & (w_reg == 2'd0) & ~w_empty;
    // a pop in the same cycle frees the slot the push needs
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_set_ovf = w_push & w_full & ~w_pop;

    always_ff @(posedge i_sys_clk) begin
        if (w_push_ok) r_mem[r_wp] <= w_rx_entry;
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + PW'(1);
            if (w_pop)     r_rp <= r_rp + PW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    logic        r_tx_nack, r_rx_ovf, r_timeout, r_tx_done, r_irq;
    logic [31:0] r_csr_do, w_rd_data, w_status;

    assign w_status = {25'd0, r_tx_done, r_timeout, r_rx_ovf, r_tx_nack,
                       w_tx_busy, w_full, ~w_empty};

    always_comb begin
        w_rd_data = 32'd0;
        case (w_reg)
            2'd0:    if (!w_empty) w_rd_data = {1'b1, 21'd0, r_mem[r_rp]};
            2'd2:    w_rd_data = w_status;
            2'd3:    w_rd_data = {29'd0, r_ctrl};
            default: w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_tx_nack <= 1'b0;
            r_rx_ovf  <= 1'b0;
            r_timeout <= 1'b0;
            r_tx_done <= 1'b0;
            r_ctrl    <= 3'd0;
            r_irq     <= 1'b0;
            r_csr_do  <= 32'd0;
        end else begin
            r_tx_nack <= w_set_nack | (r_tx_nack & ~(w_w1c & csr.csr_di[3]));
            r_rx_ovf  <= w_set_ovf  | (r_rx_ovf  & ~(w_w1c & csr.csr_di[4]));
            r_timeout <= w_set_to   | (r_timeout & ~(w_w1c & csr.csr_di[5]));
            r_tx_done <= w_set_done | (r_tx_done & ~(w_w1c & csr.csr_di[6]));
            if (w_wr && w_reg == 2'd3) r_ctrl <= csr.csr_di[2:0];
            r_irq    <= (r_ctrl[0] & ~w_empty) | (r_ctrl[1] & r_tx_done);
            r_csr_do <= w_rd ? w_rd_data : 32'd0;
        end
    end

    assign csr.csr_do = r_csr_do;
    assign o_irq      = r_irq;

    logic w_unused_bits;
    assign w_unused_bits = ^{csr.csr_a[9:2], csr.csr_di[31:8], w_rx_word[0]};

endmodule
